// File: rtl/i_bus_arbiter.sv
// Round-robin arbiter that shares one instruction-memory port between two cores.
// The grant is held until the fetch completes or the core withdraws its request.
module i_bus_arbiter #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        iREN,
  input  logic [WORD_W-1:0] iaddr0,
  input  logic [WORD_W-1:0] iaddr1,
  input  logic              ram_iwait,
  input  logic [WORD_W-1:0] ram_iload,
  output logic              ram_iREN,
  output logic [WORD_W-1:0] ram_iaddr,
  output logic [1:0]        iwait,
  output logic [WORD_W-1:0] iload0,
  output logic [WORD_W-1:0] iload1,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  fetch_cnt0,
  output logic [CNT_W-1:0]  fetch_cnt1
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t state, next_state;
  logic   last;
  logic   done0, done1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last       <= 1'b1;
      fetch_cnt0 <= '0;
      fetch_cnt1 <= '0;
    end else begin
      state <= next_state;
      if (done0) begin
        last       <= 1'b0;
        fetch_cnt0 <= fetch_cnt0 + CNT_W'(1);
      end
      if (done1) begin
        last       <= 1'b1;
        fetch_cnt1 <= fetch_cnt1 + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    ram_iREN   = 1'b0;
    ram_iaddr  = '0;
    iwait      = iREN;
    iload0     = '0;
    iload1     = '0;
    grant      = 2'b00;
    done0      = 1'b0;
    done1      = 1'b0;
    case (state)
      IDLE: begin
        case (iREN)
          2'b01:   next_state = SERVE0;
          2'b10:   next_state = SERVE1;
          2'b11:   next_state = last ? SERVE0 : SERVE1;
          default: next_state = IDLE;
        endcase
      end
      SERVE0: begin
        grant     = 2'b01;
        ram_iREN  = iREN[0];
        ram_iaddr = iaddr0;
        iwait[0]  = iREN[0] & ram_iwait;
        iload0    = ram_iload;
        // Leave on completion or withdrawal; the other core goes straight in if waiting.
        if (!iREN[0] || !ram_iwait) begin
          done0      = iREN[0];
          next_state = iREN[1] ? SERVE1 : IDLE;
        end
      end
      SERVE1: begin
        grant     = 2'b10;
        ram_iREN  = iREN[1];
        ram_iaddr = iaddr1;
        iwait[1]  = iREN[1] & ram_iwait;
        iload1    = ram_iload;
        if (!iREN[1] || !ram_iwait) begin
          done1      = iREN[1];
          next_state = iREN[0] ? SERVE0 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i_bus_arbiter.sv
// Directed plus randomized bench for i_bus_arbiter against an owner/last/count reference model.
module tb_i_bus_arbiter;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [1:0]        iREN = 2'b00;
  logic [WORD_W-1:0] iaddr0 = '0, iaddr1 = '0;
  logic              ram_iwait = 1'b1;
  logic [WORD_W-1:0] ram_iload = '0;
  logic              ram_iREN;
  logic [WORD_W-1:0] ram_iaddr;
  logic [1:0]        iwait;
  logic [WORD_W-1:0] iload0, iload1;
  logic [1:0]        grant;
  logic [CNT_W-1:0]  fetch_cnt0, fetch_cnt1;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port (-1 = nobody), who was served last, completions.
  int m_owner = -1;
  int m_last  = 1;
  int m_cnt[2] = '{0, 0};

  i_bus_arbiter #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .ram_iwait(ram_iwait), .ram_iload(ram_iload), .ram_iREN(ram_iREN),
    .ram_iaddr(ram_iaddr), .iwait(iwait), .iload0(iload0), .iload1(iload1),
    .grant(grant), .fetch_cnt0(fetch_cnt0), .fetch_cnt1(fetch_cnt1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, compare against the model, then advance it.
  task automatic cyc(input logic rst, input logic [1:0] ren, input logic [31:0] a0,
                     input logic [31:0] a1, input logic w, input logic [31:0] ld);
    logic [1:0]  e_wait;
    logic [31:0] e_addr;
    logic        e_req;
    int          other;
    @(negedge CLK);
    RST = rst; iREN = ren; iaddr0 = a0; iaddr1 = a1; ram_iwait = w; ram_iload = ld;
    #1;
    e_req  = (m_owner >= 0) ? ren[m_owner] : 1'b0;
    e_addr = (m_owner == 0) ? a0 : (m_owner == 1) ? a1 : 32'h0;
    e_wait = ren;
    if (m_owner >= 0) e_wait[m_owner] = ren[m_owner] & w;
    chk("ram_iREN", 32'(ram_iREN), 32'(e_req));
    chk("ram_iaddr", ram_iaddr, e_addr);
    chk("iwait", 32'(iwait), 32'(e_wait));
    chk("iload0", iload0, (m_owner == 0) ? ld : 32'h0);
    chk("iload1", iload1, (m_owner == 1) ? ld : 32'h0);
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
    chk("fetch_cnt0", 32'(fetch_cnt0), 32'(m_cnt[0]));
    chk("fetch_cnt1", 32'(fetch_cnt1), 32'(m_cnt[1]));
    if (rst) begin
      m_owner = -1; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_owner < 0) begin
      if (ren == 2'b11)      m_owner = 1 - m_last;
      else if (ren == 2'b01) m_owner = 0;
      else if (ren == 2'b10) m_owner = 1;
    end else begin
      other = 1 - m_owner;
      if (ren[m_owner] && !w) begin
        m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CNT_W);
        m_last = m_owner;
        m_owner = ren[other] ? other : -1;
      end else if (!ren[m_owner]) begin
        m_owner = ren[other] ? other : -1;
      end
    end
  endtask

  initial begin
    // Test 1: reset then a single core-0 fetch with three wait cycles.
    cyc(1, 2'b00, 0, 0, 1, 0);
    chk("t1_rst_grant", 32'(grant), 32'h0);
    cyc(0, 2'b01, 32'h40, 0, 1, 0);
    chk("t1_idle_req", 32'(ram_iREN), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b01, 32'h40, 0, 1, 0);
      chk("t1_req", 32'(ram_iREN), 32'h1);
      chk("t1_addr", ram_iaddr, 32'h40);
      chk("t1_wait", 32'(iwait[0]), 32'h1);
    end
    cyc(0, 2'b01, 32'h40, 0, 0, 32'h2402_0001);
    chk("t1_done_wait", 32'(iwait[0]), 32'h0);
    chk("t1_load", iload0, 32'h2402_0001);
    cyc(0, 2'b00, 0, 0, 1, 0);
    chk("t1_cnt0", 32'(fetch_cnt0), 32'h1);
    chk("t1_idle", 32'(grant), 32'h0);

    // Test 2: simultaneous requests alternate with no idle gap.
    cyc(1, 2'b00, 0, 0, 1, 0);
    cyc(0, 2'b11, 32'h100, 32'h200, 1, 0);
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(0, 2'b11, 32'h100, 32'h200, (k < 2), 32'hA000 + 32'(g));
        chk("t2_grant", 32'(grant), (g % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_addr", ram_iaddr, (g % 2 == 0) ? 32'h100 : 32'h200);
        if (g % 2 == 0) chk("t2_wait1", 32'(iwait[1]), 32'h1);
      end
    end

    // Test 3: core 1 withdraws mid-fetch while core 0 waits.
    cyc(1, 2'b00, 0, 0, 1, 0);
    cyc(0, 2'b10, 32'h11, 32'h22, 1, 0);
    cyc(0, 2'b11, 32'h11, 32'h22, 1, 0);
    chk("t3_serve1", 32'(grant), 32'h2);
    cyc(0, 2'b01, 32'h11, 32'h22, 1, 0);
    chk("t3_drop", 32'(ram_iREN), 32'h0);
    cyc(0, 2'b01, 32'h11, 32'h22, 1, 0);
    chk("t3_addr", ram_iaddr, 32'h11);
    chk("t3_cnt1", 32'(fetch_cnt1), 32'h0);

    // Test 4: reset during SERVE0 with the fetch outstanding.
    cyc(0, 2'b01, 32'h11, 0, 0, 0);
    cyc(0, 2'b01, 32'h44, 0, 1, 0);
    cyc(0, 2'b01, 32'h44, 0, 1, 0);
    chk("t4_pre_cnt0", 32'(fetch_cnt0), 32'h1);
    cyc(1, 2'b01, 32'h44, 0, 1, 0);
    cyc(0, 2'b11, 32'h44, 32'h55, 1, 0);
    chk("t4_grant", 32'(grant), 32'h0);
    chk("t4_req", 32'(ram_iREN), 32'h0);
    chk("t4_cnt0", 32'(fetch_cnt0), 32'h0);
    cyc(0, 2'b11, 32'h44, 32'h55, 1, 0);
    chk("t4_regrant", 32'(grant), 32'h1);

    // Test 5: sixteen lone core-1 fetches wrap the 4-bit counter.
    cyc(1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 2'b10, 0, 32'h300 + 32'(i), 0, 32'(i));
      if (i == 31) chk("t5_cnt1_15", 32'(fetch_cnt1), 32'hF);
    end
    cyc(0, 2'b00, 0, 0, 1, 0);
    chk("t5_wrap", 32'(fetch_cnt1), 32'h0);
    chk("t5_cnt0", 32'(fetch_cnt0), 32'h0);

    // Test 6: lone core 0 back-to-back completes every other cycle.
    cyc(1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 2'b01, 32'h80, 0, 0, 32'h77);
      chk("t6_grant", 32'(grant), (i % 2 == 1) ? 32'h1 : 32'h0);
      if (i % 2 == 0) chk("t6_cnt0", 32'(fetch_cnt0), 32'(i / 2));
    end

    // Randomized traffic including occasional reset.
    cyc(1, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
          ($urandom_range(0, 2) != 0), $urandom);
      chk("inv_onehot", 32'(grant == 2'b11), 32'h0);
      if (iREN == 2'b11) chk("inv_wait", 32'(iwait == 2'b00), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
